// File: rtl/serial_bit_assembler.sv
// Serial-to-parallel receiver: assembles a 1-bit stream into WIDTH-bit words with
// per-word selectable bit order and a one-word valid/ready output holding register.
module serial_bit_assembler #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CNT_W-1:0] bit_count
);

  logic [WIDTH-1:0] r_shiftReg;
  logic [CNT_W-1:0] r_bitCount;
  logic             r_orderQ;
  logic [WIDTH-1:0] r_wordOut;
  logic             r_wordValid;
  logic             r_overrun;

  logic             w_firstBit;
  logic             w_order;
  logic [WIDTH-1:0] w_shiftBase;
  logic [WIDTH-1:0] w_shifted;
  logic             w_complete;
  logic             w_drain;

  // A sync pulse makes the incoming bit the first of a fresh word, so its order is relatched too.
  always_comb begin
    w_firstBit  = frame_sync || (r_bitCount == '0);
    w_order     = w_firstBit ? msb_first : r_orderQ;
    w_shiftBase = frame_sync ? '0 : r_shiftReg;
    if (w_order)
      w_shifted = {w_shiftBase[WIDTH-2:0], bit_in};
    else
      w_shifted = {bit_in, w_shiftBase[WIDTH-1:1]};
    w_complete  = bit_valid && !frame_sync && (r_bitCount == CNT_W'(WIDTH - 1));
    w_drain     = r_wordValid && word_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg <= '0;
      r_bitCount <= '0;
      r_orderQ   <= 1'b0;
    end else if (bit_valid) begin
      r_shiftReg <= w_shifted;
      if (w_firstBit)
        r_orderQ <= msb_first;
      if (frame_sync)
        r_bitCount <= CNT_W'(1);
      else if (w_complete)
        r_bitCount <= '0;
      else
        r_bitCount <= r_bitCount + CNT_W'(1);
    end else if (frame_sync) begin
      r_bitCount <= '0;
    end
  end

  // A completed word is dropped only when the holding register is full and not draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wordOut   <= '0;
      r_wordValid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_complete && (!r_wordValid || w_drain)) begin
        r_wordOut   <= w_shifted;
        r_wordValid <= 1'b1;
      end else if (w_drain) begin
        r_wordValid <= 1'b0;
      end
      if (w_complete && r_wordValid && !word_ready)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  assign word_out   = r_wordOut;
  assign word_valid = r_wordValid;
  assign overrun    = r_overrun;
  assign bit_count  = r_bitCount;

endmodule

// File: tb/tb_serial_bit_assembler.sv
// Directed self-checking bench for serial_bit_assembler (WIDTH=8).
module tb_serial_bit_assembler;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       msb_first;
  logic       frame_sync;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       overrun;
  logic       overrun_clr;
  logic [3:0] bit_count;

  int total = 0;
  int bad   = 0;

  serial_bit_assembler #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .msb_first(msb_first), .frame_sync(frame_sync), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .overrun(overrun),
    .overrun_clr(overrun_clr), .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock with the given bit presented; returns #1 after the edge with bit_valid dropped.
  task automatic applyStimulus(input logic b, input logic msb, input logic fs);
    bit_in     = b;
    msb_first  = msb;
    frame_sync = fs;
    bit_valid  = 1'b1;
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmits w in the order selected by msb (MSB-first sends w[7] first).
  task automatic sendWord(input logic [7:0] w, input logic msb);
    for (int i = 0; i < 8; i++)
      applyStimulus(msb ? w[7-i] : w[i], msb, 1'b0);
  endtask

  logic [7:0] pattern;
  int         earlyValid;

  initial begin
    rst_n = 1'b0; bit_in = 0; bit_valid = 0; msb_first = 0; frame_sync = 0;
    word_ready = 1'b1; overrun_clr = 1'b0;
    #1;
    checkOutput("rst_word_out", word_out, 0);
    checkOutput("rst_valid", word_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_count", bit_count, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // 1: MSB-first bits 1,0,1,1,0,0,1,0
    pattern = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(pattern[7-i], 1'b1, 1'b0);
      if (i < 7) checkOutput("t1_no_early_valid", word_valid, 0);
    end
    checkOutput("t1_valid", word_valid, 1);
    checkOutput("t1_word", word_out, 8'hB2);
    checkOutput("t1_count_wrap", bit_count, 0);
    idle(1);
    checkOutput("t1_valid_one_clk", word_valid, 0);
    checkOutput("t1_word_kept", word_out, 8'hB2);

    // 2: same bit stream LSB-first, then again with msb_first toggled mid-word
    for (int i = 0; i < 8; i++) applyStimulus(pattern[7-i], 1'b0, 1'b0);
    checkOutput("t2_word_lsb", word_out, 8'h4D);
    checkOutput("t2_valid", word_valid, 1);
    idle(1);
    for (int i = 0; i < 8; i++) applyStimulus(pattern[7-i], (i == 0) ? 1'b0 : 1'b1, 1'b0);
    checkOutput("t2_word_toggle", word_out, 8'h4D);
    idle(1);

    // 3: consumer stalls, second word is dropped
    word_ready = 1'b0;
    sendWord(8'hA5, 1'b1);
    checkOutput("t3_first_word", word_out, 8'hA5);
    checkOutput("t3_no_overrun_yet", overrun, 0);
    sendWord(8'h3C, 1'b1);
    checkOutput("t3_word_held", word_out, 8'hA5);
    checkOutput("t3_valid_held", word_valid, 1);
    checkOutput("t3_overrun", overrun, 1);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    checkOutput("t3_drained", word_valid, 0);
    checkOutput("t3_overrun_sticky", overrun, 1);
    idle(2);
    checkOutput("t3_overrun_still", overrun, 1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    checkOutput("t3_overrun_cleared", overrun, 0);

    // 4: drain and completion in the same clock
    sendWord(8'h11, 1'b1);
    checkOutput("t4_hold", word_out, 8'h11);
    pattern = 8'h22;
    for (int i = 0; i < 8; i++) begin
      word_ready = (i == 7);
      applyStimulus(pattern[7-i], 1'b1, 1'b0);
    end
    word_ready = 1'b1;
    checkOutput("t4_word", word_out, 8'h22);
    checkOutput("t4_valid", word_valid, 1);
    checkOutput("t4_no_overrun", overrun, 0);
    idle(1);

    // 5: frame_sync with a bit, then frame_sync alone
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_count3", bit_count, 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_count_sync", bit_count, 1);
    pattern = 8'b1110_0000;
    for (int i = 0; i < 7; i++) applyStimulus(pattern[7-i], 1'b1, 1'b0);
    checkOutput("t5_word", word_out, 8'hF0);
    checkOutput("t5_valid", word_valid, 1);
    idle(1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    frame_sync = 1'b1;
    idle(1);
    frame_sync = 1'b0;
    checkOutput("t5_count_sync0", bit_count, 0);
    checkOutput("t5_no_word", word_valid, 0);
    sendWord(8'h5A, 1'b1);
    checkOutput("t5_word_after", word_out, 8'h5A);
    idle(1);

    // 6: reset mid-word, then a word with random gaps
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_word", word_out, 0);
    checkOutput("t6_rst_count", bit_count, 0);
    checkOutput("t6_rst_valid", word_valid, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    checkOutput("t6_post_rst_valid", word_valid, 0);
    pattern    = 8'h81;
    earlyValid = 0;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        idle(1);
        earlyValid += int'(word_valid);
      end
      applyStimulus(pattern[7-i], 1'b1, 1'b0);
      if (i < 7) earlyValid += int'(word_valid);
    end
    checkOutput("t6_no_early_word", earlyValid, 0);
    checkOutput("t6_word", word_out, 8'h81);
    checkOutput("t6_valid", word_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
